if_id_stage: RTL

IF_ID_STAGE -- requirements
Module: if_id_stage

---
 rtl/if_id_stage.sv | 87 ++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// Fetch PC generation plus the IF/ID pipeline register, with stall and flush counters.
// Latency: one cycle from fetch to IF/ID. Flow control: pc_write/IF_ID_write hold state; branch_taken flushes with a bubble.
module if_id_stage #(
    parameter int unsigned     XLEN      = 64,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_write,
    input  logic            IF_ID_write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [31:0]     IF_ID_instr,
    output logic            IF_ID_valid,
    output logic [4:0]      IF_ID_rs1,
    output logic [4:0]      IF_ID_rs2,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            vld;
    } ifid_t;

    localparam ifid_t BUBBLE = '{pc: '0, instr: NOP_INSTR, vld: 1'b0};

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt;
    ifid_t           ifid_q;
    ifid_t           ifid_nxt;
    logic [31:0]     stall_q;
    logic [31:0]     flush_q;
    logic            stall_inc;

    // A redirect outranks both the stall and the IF/ID load enable.
    always_comb begin
        pc_nxt   = pc_q;
        ifid_nxt = ifid_q;
        if (branch_taken) begin
            pc_nxt   = branch_target & ~XLEN'(3);
            ifid_nxt = BUBBLE;
        end else begin
            if (pc_write) begin
                pc_nxt = pc_q + XLEN'(4);
            end
            if (IF_ID_write) begin
                ifid_nxt = '{pc: pc_q, instr: imem_rdata, vld: 1'b1};
            end
        end
    end

    assign stall_inc = !branch_taken && !pc_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            ifid_q  <= BUBBLE;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pc_q   <= pc_nxt;
            ifid_q <= ifid_nxt;
            if (stall_inc && (stall_q != 32'hFFFF_FFFF)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (branch_taken && (flush_q != 32'hFFFF_FFFF)) begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    assign imem_addr   = pc_q;
    assign IF_ID_pc    = ifid_q.pc;
    assign IF_ID_instr = ifid_q.instr;
    assign IF_ID_valid = ifid_q.vld;
    assign IF_ID_rs1   = ifid_q.instr[19:15];
    assign IF_ID_rs2   = ifid_q.instr[24:20];
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule
